// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for an N-wide in-order pipeline: per-register load scoreboard,
// cross-lane load-use checks, ordered stalls, oldest-wins redirect/flush,
// saturating perf counters and a stall watchdog.
module hazard_scoreboard_unit #(
  parameter int LANES    = 2,
  parameter int REG_BITS = 5,
  parameter int LOAD_LAT = 1,
  parameter int WD_LIMIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*REG_BITS-1:0] rsD,
  input  logic [LANES*REG_BITS-1:0] rtD,
  input  logic [LANES-1:0]          validD,
  input  logic [LANES-1:0]          memReadD,
  input  logic [LANES*REG_BITS-1:0] writeRegisterD,
  input  logic [LANES-1:0]          validE,
  input  logic [LANES-1:0]          memReadE,
  input  logic [LANES*REG_BITS-1:0] writeRegisterE,
  input  logic [LANES-1:0]          branchE,
  input  logic [LANES-1:0]          takenBranchE,
  input  logic [LANES-1:0]          predictionE,
  input  logic [LANES-1:0]          pcSrcE,
  output logic [LANES-1:0]          Stall,
  output logic [LANES-1:0]          Flush,
  output logic [LANES-1:0]          CPCSignal,
  output logic [LANES-1:0]          killE,
  output logic [CNT_W-1:0]          stallCount,
  output logic [CNT_W-1:0]          flushCount,
  output logic                      deadlock
);

  localparam int SB_W  = (LOAD_LAT > 2) ? $clog2(LOAD_LAT) : 1;
  localparam int NREGS = 1 << REG_BITS;
  localparam int WD_W  = $clog2(WD_LIMIT + 1);
  localparam logic [SB_W-1:0] SB_INIT = SB_W'(LOAD_LAT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WD_LIMIT);

  logic [SB_W-1:0]     r_sb [NREGS];
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic [WD_W-1:0]     r_wd;
  logic                r_dead;

  logic [REG_BITS-1:0] w_rs   [LANES];
  logic [REG_BITS-1:0] w_rt   [LANES];
  logic [REG_BITS-1:0] w_wr_d [LANES];
  logic [REG_BITS-1:0] w_wr_e [LANES];
  logic [LANES-1:0]    w_mis;
  logic [LANES-1:0]    w_live;
  logic [LANES-1:0]    w_haz;
  logic [LANES-1:0]    w_stall_raw;
  logic [NREGS-1:0]    w_set;
  logic                w_found;

  // Unpack per-lane fields and classify each execute lane.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_rs[gi]   = rsD[gi*REG_BITS +: REG_BITS];
    assign w_rt[gi]   = rtD[gi*REG_BITS +: REG_BITS];
    assign w_wr_d[gi] = writeRegisterD[gi*REG_BITS +: REG_BITS];
    assign w_wr_e[gi] = writeRegisterE[gi*REG_BITS +: REG_BITS];
    assign w_mis[gi]  = validE[gi] & ((branchE[gi] & (takenBranchE[gi] ^ predictionE[gi])) | pcSrcE[gi]);
    assign w_live[gi] = validE[gi] & memReadE[gi] & ~killE[gi] & (w_wr_e[gi] != '0);
  end

  // Oldest redirecting lane wins: it and all younger lanes flush, younger execute lanes die.
  always_comb begin
    w_found   = 1'b0;
    Flush     = '0;
    killE     = '0;
    CPCSignal = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_found) begin
        Flush[i] = 1'b1;
        killE[i] = 1'b1;
      end else if (w_mis[i]) begin
        w_found      = 1'b1;
        Flush[i]     = 1'b1;
        CPCSignal[i] = branchE[i] & (takenBranchE[i] ^ predictionE[i]);
      end
    end
  end

  // Per-lane hazard: live execute load, pending scoreboard entry, or older decode load.
  always_comb begin : hazard_detect
    logic [REG_BITS-1:0] w_src;
    logic                w_hit;
    w_haz = '0;
    w_src = '0;
    w_hit = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      for (int s = 0; s < 2; s++) begin
        w_src = (s == 0) ? w_rs[j] : w_rt[j];
        w_hit = 1'b0;
        if (validD[j] && (w_src != '0)) begin
          if (r_sb[w_src] != '0) w_hit = 1'b1;
          for (int i = 0; i < LANES; i++)
            if (w_live[i] && (w_wr_e[i] == w_src)) w_hit = 1'b1;
          for (int k = 0; k < j; k++)
            if (validD[k] && memReadD[k] && (w_wr_d[k] != '0) && (w_wr_d[k] == w_src)) w_hit = 1'b1;
        end
        if (w_hit) w_haz[j] = 1'b1;
      end
    end
  end

  // A stalled lane holds every younger lane; a flush discards decode so it cancels stalls.
  always_comb begin
    w_stall_raw = '0;
    for (int j = 0; j < LANES; j++)
      w_stall_raw[j] = w_haz[j] | ((j > 0) ? w_stall_raw[(j > 0) ? j-1 : 0] : 1'b0);
    Stall = (|Flush) ? '0 : w_stall_raw;
  end

  // Registers receiving a new live load this cycle.
  always_comb begin
    w_set = '0;
    for (int i = 0; i < LANES; i++)
      if (w_live[i]) w_set[w_wr_e[i]] = 1'b1;
  end

  // Scoreboard: new loads load the latency count, pending entries count down.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (!rst)               r_sb[r] <= '0;
      else if (w_set[r])      r_sb[r] <= SB_INIT;
      else if (r_sb[r] != '0) r_sb[r] <= r_sb[r] - 1'b1;
    end
  end

  // Saturating stall/flush perf counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((|Stall) && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if ((|Flush) && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // Watchdog: count consecutive stalled cycles, latch deadlock when the limit is reached.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wd   <= '0;
      r_dead <= 1'b0;
    end else if (|Stall) begin
      if (r_wd != WD_MAX) r_wd <= r_wd + 1'b1;
      if (r_wd >= WD_MAX - 1'b1) r_dead <= 1'b1;
    end else begin
      r_wd <= '0;
    end
  end

  assign stallCount = r_stall_cnt;
  assign flushCount = r_flush_cnt;
  assign deadlock   = r_dead;

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised hazard unit for the N-wide in-order superscalar pipeline. It replaces the fixed two-lane, single-cycle load-use stall with a per-register load scoreboard that supports configurable load-use latency. It adds cross-lane dependency checks, ordered stall propagation, oldest-wins branch-mispredict flush/redirect, perf counters and a stall watchdog. It sits beside the decode/execute pipeline registers and drives their stall and flush controls.

Parameters:
LANES, 2, number of issue lanes; lane 0 is oldest.
REG_BITS, 5, register index width; register 0 is never a hazard.
LOAD_LAT, 1, stall cycles required by a consumer directly behind a load (≥1; 1 = classic single-cycle load-use).
WD_LIMIT, 15, consecutive stall cycles after which the watchdog flags deadlock.
CNT_W, 16, perf counter width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-low reset.
rsD  in  LANES*REG_BITS  decode source rs per lane; lane i occupies bits [i*REG_BITS +: REG_BITS].
rtD  in  LANES*REG_BITS  decode source rt per lane.
validD  in  LANES  decode lane holds a real instruction.
memReadD  in  LANES  decode lane is a load.
writeRegisterD  in  LANES*REG_BITS  decode lane destination.
validE  in  LANES  execute lane holds a real instruction.
memReadE  in  LANES  execute lane is a load.
writeRegisterE  in  LANES*REG_BITS  execute lane destination.
branchE  in  LANES  execute lane is a conditional branch.
takenBranchE  in  LANES  resolved branch outcome.
predictionE  in  LANES  predicted outcome.
pcSrcE  in  LANES  unconditional redirect (jump) in execute.
Stall  out  LANES  hold decode lane, insert bubble into execute.
Flush  out  LANES  squash the lane's younger-path state.
CPCSignal  out  LANES  one-hot; the lane whose branch supplies the corrected PC.
killE  out  LANES  execute lanes younger than the redirecting lane, squashed this cycle.
stallCount  out  CNT_W  cycles with any Stall bit set; saturating.
flushCount  out  CNT_W  cycles with any Flush bit set; saturating.
deadlock  out  1  sticky watchdog error.

Behaviour:
- Reset (rst=0 at a clock edge): all scoreboard counters=0, stallCount=0, flushCount=0, deadlock=0, watchdog counter=0. Combinational outputs follow the cleared state.
- Redirect per lane i:
  - mis[i] = validE[i] & ((branchE[i] & (takenBranchE[i]^predictionE[i])) | pcSrcE[i]).
  - r = lowest i with mis[i]=1.
  - CPCSignal[r] = branchE[r] & mispredict; all other CPCSignal bits are 0. A pure pcSrc redirect gives CPCSignal=0.
  - Flush[j] = 1 for all j ≥ r. killE[j] = 1 for all j > r. With no mis, all three outputs are 0.
- Load entry into scoreboard: execute lane i with validE & memReadE & !killE[i] & writeRegisterE≠0 is a live load.
  - At the clock edge, sb[writeRegisterE[i]] ← LOAD_LAT-1.
  - Every other nonzero sb entry decrements by 1 each cycle.
  - If a set and a decrement hit the same register in the same cycle, the set wins. Multiple lanes setting the same register load the same value.
  - Counter width = max(1, clog2(LOAD_LAT)).
- Hazard for decode lane j (requires validD[j]; rs/rt = 0 never matches):
  - (a) the source equals the writeRegisterE of a live execute load;
  - (b) sb[source] ≠ 0;
  - (c) the source equals writeRegisterD[k] of an older decode lane k<j with validD[k] & memReadD[k] & writeRegisterD[k]≠0.
- Ordering: Stall[j] = OR of hazard[0..j]. A stalled lane stalls all younger lanes.
- Flush priority: any Flush bit forces Stall to all-zero, because the flush discards decode.
- With LOAD_LAT=1, a consumer stalls exactly one cycle (case a only), matching the two-lane legacy behaviour.
- stallCount increments on cycles with |Stall. flushCount increments on cycles with |Flush. Both saturate at all-ones.
- Watchdog:
  - Counter increments while |Stall and resets to 0 when Stall is all-zero.
  - When the counter reaches WD_LIMIT, deadlock ← 1 and stays 1 until reset.
  - The watchdog counter saturates at WD_LIMIT.
- Reset asserted mid-stall: the scoreboard is cleared, so stalls end the next cycle.

Test Plan:
1. LANES=2, LOAD_LAT=1. Lane0 E load to r5 (validE=01, memReadE=01); decode lane1 rsD=r5 → Stall=10 for one cycle, then 00. sb stays 0.
2. LOAD_LAT=3. E load to r7; decode lane0 rtD=r7 held constant → Stall=11 for exactly 3 cycles (t, t+1, t+2), 00 at t+3. stallCount=3.
3. Same bundle: lane0 memReadD to r9, lane1 rsD=r9, no E hazards → Stall=10. Same source on r0 → Stall=00.
4. Lane0 branch mispredict (branchE=11, takenBranchE=01, predictionE=00) with lane1 E load to r4 → CPCSignal=01, Flush=11, killE=10, Stall=00. r4 is not entered into the scoreboard (decode r4 consumer next cycle → no stall).
5. Lane1-only pcSrcE=10 → Flush=10, CPCSignal=00, killE=00. flushCount increments by 1.
6. Hold a hazard for 15 cycles (WD_LIMIT=15) → deadlock=1 at the 15th stalled cycle and sticky after the stall clears. Assert rst=0 → deadlock=0, counters=0, Stall=00 on the following cycle.
